// File: rtl/mnist_input_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mnist_input_pkg
// Brief    : Shared constants, pixel type and quantizer for the MNIST packer.
// Revision : 1.0 - initial release
// ============================================================================
package mnist_input_pkg;

    localparam int c_NUM_PIXELS = 784;
    localparam int c_PIXEL_W    = 8;

    typedef logic [c_PIXEL_W-1:0] pixel_t;

    // Result is right-aligned in a full pixel_t; callers keep the low in_bits.
    function automatic pixel_t quantize(input pixel_t pixel, input int in_bits,
                                        input pixel_t thresh);
        pixel_t q;
        if (in_bits == 1) begin
            q = (pixel >= thresh) ? pixel_t'(1) : pixel_t'(0);
        end else begin
            q = pixel >> (c_PIXEL_W - in_bits);
        end
        return q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mnist_pixel_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : mnist_pixel_quantizer
// Brief    : Combinational reduction of one grayscale pixel to IN_BITS bits.
// Revision : 1.0 - initial release
// ============================================================================
module mnist_pixel_quantizer
    import mnist_input_pkg::*;
#(
    parameter int     IN_BITS = 1,
    parameter pixel_t THRESH  = 8'd128
) (
    input  logic [c_PIXEL_W-1:0] i_pixel,
    output logic [IN_BITS-1:0]   o_q
);

    assign o_q = IN_BITS'(quantize(i_pixel, IN_BITS, THRESH));

endmodule
`default_nettype wire

// File: rtl/mnist_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : mnist_input_packer
// Brief    : Streams pixels into a fill register and double-buffers whole
//            quantized images towards layer 0.
// Revision : 1.0 - initial release
// ============================================================================
module mnist_input_packer
    import mnist_input_pkg::*;
#(
    parameter int     NUM_PIXELS = c_NUM_PIXELS,
    parameter int     IN_BITS    = 1,
    parameter pixel_t THRESH     = 8'd128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [c_PIXEL_W-1:0]          s_pixel,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [NUM_PIXELS*IN_BITS-1:0] m_data,
    output logic                          err_len
);

    localparam int c_IDX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int c_DATA_W = NUM_PIXELS * IN_BITS;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_PIXELS - 1);

    localparam logic [0:0] c_ST_FILL = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    logic [0:0]          r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_DATA_W-1:0] r_fill;
    logic [c_DATA_W-1:0] r_data;
    logic                r_mvalid;
    logic                r_sready;
    logic                r_err;

    logic [IN_BITS-1:0]  w_q;
    logic [c_DATA_W-1:0] w_fill_next;
    logic                w_beat;
    logic                w_final;
    logic                w_out_free;

    mnist_pixel_quantizer #(
        .IN_BITS (IN_BITS),
        .THRESH  (THRESH)
    ) u_quant (
        .i_pixel (s_pixel),
        .o_q     (w_q)
    );

    // Fill contents including the beat being accepted this cycle, so a
    // completed image can go straight to the output register.
    always_comb begin
        w_fill_next = r_fill;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_fill_next[i*IN_BITS +: IN_BITS] = w_q;
            end
        end
    end

    assign w_beat     = s_valid && r_sready;
    assign w_final    = (r_idx == c_LAST_IDX);
    assign w_out_free = !r_mvalid || m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_FILL;
            r_idx    <= '0;
            r_fill   <= '0;
            r_data   <= '0;
            r_mvalid <= 1'b0;
            r_sready <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_ST_FILL: begin
                    r_sready <= 1'b1;
                    if (r_mvalid && m_ready) begin
                        r_mvalid <= 1'b0;
                    end
                    if (w_beat) begin
                        r_fill <= w_fill_next;
                        if (w_final) begin
                            r_idx <= '0;
                            r_err <= !s_last;
                            if (w_out_free) begin
                                r_data   <= w_fill_next;
                                r_mvalid <= 1'b1;
                            end else begin
                                r_state  <= c_ST_HOLD;
                                r_sready <= 1'b0;
                            end
                        end else if (s_last) begin
                            r_idx <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_ST_HOLD: begin
                    // Output stays valid: the held image replaces the one leaving.
                    if (m_ready) begin
                        r_data   <= r_fill;
                        r_state  <= c_ST_FILL;
                        r_sready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_FILL;
                end
            endcase
        end
    end

    assign s_ready = r_sready;
    assign m_valid = r_mvalid;
    assign m_data  = r_data;
    assign err_len = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mnist_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mnist_input_packer
// Brief    : Table vectors and corner sequences on 4-pixel packers, random
//            backpressure on a full 784-pixel packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mnist_input_packer;

    localparam int NC = 784;
    localparam int BC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s_valid, s_last, m_ready;
    logic [7:0] s_pixel;
    logic       a_s_ready, a_m_valid, a_err;
    logic [3:0] a_data;
    logic       b_s_ready, b_m_valid, b_err;
    logic [7:0] b_data;

    logic            c_s_valid, c_s_last, c_m_ready;
    logic [7:0]      c_s_pixel;
    logic            c_s_ready, c_m_valid, c_err;
    logic [NC*BC-1:0] c_data;

    int checks = 0;
    int errors = 0;

    mnist_input_packer #(.NUM_PIXELS(4), .IN_BITS(1), .THRESH(8'd128)) u_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_pixel(s_pixel), .s_last(s_last), .m_valid(a_m_valid),
        .m_ready(m_ready), .m_data(a_data), .err_len(a_err));

    mnist_input_packer #(.NUM_PIXELS(4), .IN_BITS(2), .THRESH(8'd128)) u_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_pixel(s_pixel), .s_last(s_last), .m_valid(b_m_valid),
        .m_ready(m_ready), .m_data(b_data), .err_len(b_err));

    mnist_input_packer #(.NUM_PIXELS(NC), .IN_BITS(BC), .THRESH(8'd128)) u_c (
        .clk(clk), .rst(rst), .s_valid(c_s_valid), .s_ready(c_s_ready),
        .s_pixel(c_s_pixel), .s_last(c_s_last), .m_valid(c_m_valid),
        .m_ready(c_m_ready), .m_data(c_data), .err_len(c_err));

    typedef struct packed {
        logic [31:0] px;   // pixel k in px[8k +: 8]
        logic [3:0]  ea;   // expected 1-bit packing
        logic [7:0]  eb;   // expected 2-bit packing
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic last, input logic mr);
        int guard;
        guard = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_pixel = p;
        s_last  = last;
        m_ready = mr;
        while (!a_s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!a_s_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=s_ready_low required=s_ready_high");
        end
        @(posedge clk);
    endtask

    task automatic send(input logic [31:0] px, input int n, input int last_at, input logic mr);
        for (int k = 0; k < n; k++) push(px[8*k +: 8], (k == last_at), mr);
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_pixel = 8'($urandom);
    endtask

    task automatic chk_img(input string tag, input int v);
        chk({tag, "_a_valid"}, a_m_valid, 1);
        chk({tag, "_b_valid"}, b_m_valid, 1);
        chk({tag, "_a_data"},  a_data, tbl[v].ea);
        chk({tag, "_b_data"},  b_data, tbl[v].eb);
    endtask

    initial begin
        logic [NC*BC-1:0] exp_q [$];
        int  got;
        int  cyc;
        bit  tmo;

        tbl[0] = '{px: {8'd127, 8'd128, 8'd50, 8'd200}, ea: 4'b0101, eb: 8'b01_10_00_11};
        tbl[1] = '{px: {8'hC0, 8'h80, 8'h40, 8'h00},    ea: 4'b1100, eb: 8'b11_10_01_00};
        tbl[2] = '{px: {8'd0, 8'd255, 8'd0, 8'd255},    ea: 4'b0101, eb: 8'b00_11_00_11};
        tbl[3] = '{px: {8'd255, 8'd129, 8'd128, 8'd127}, ea: 4'b1110, eb: 8'b11_10_10_01};
        tbl[4] = '{px: {8'hFF, 8'h7F, 8'h3F, 8'hBF},    ea: 4'b1001, eb: 8'b11_01_00_10};

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_pixel = 8'd0; m_ready = 1'b0;
        c_s_valid = 1'b0; c_s_last = 1'b0; c_s_pixel = 8'd0; c_m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_sready", a_s_ready, 0);
        chk("rst_a_mvalid", a_m_valid, 0);
        chk("rst_a_data",   a_data, 0);
        chk("rst_b_data",   b_data, 0);
        chk("rst_a_err",    a_err, 0);
        chk("rst_c_sready", c_s_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_a_sready", a_s_ready, 1);
        chk("post_rst_c_sready", c_s_ready, 1);

        // Table: one image per entry, consumer always ready.
        for (int v = 0; v < 5; v++) begin
            send(tbl[v].px, 4, 3, 1'b1);
            idle();
            chk_img($sformatf("tbl%0d", v), v);
            chk("tbl_err", a_err, 0);
            idle();
            chk("tbl_drain", a_m_valid, 0);
        end

        // Missing s_last on the final beat: image still emitted, err pulses.
        send(tbl[2].px, 4, -1, 1'b1);
        idle();
        chk_img("nolast", 2);
        chk("nolast_a_err", a_err, 1);
        chk("nolast_b_err", b_err, 1);
        idle();
        chk("nolast_err_clr", a_err, 0);

        // Premature s_last on the 3rd pixel.
        send(tbl[1].px, 3, 2, 1'b1);
        idle();
        chk("early_err", a_err, 1);
        chk("early_mvalid", a_m_valid, 0);
        idle();
        chk("early_err_clr", a_err, 0);
        chk("early_mvalid2", b_m_valid, 0);
        send(tbl[3].px, 4, 3, 1'b1);
        idle();
        chk_img("after_early", 3);

        // Two images against a stalled consumer: second one parks in HOLD.
        send(tbl[0].px, 4, 3, 1'b0);
        idle();
        chk_img("hold_img1", 0);
        chk("hold_sready1", a_s_ready, 1);
        send(tbl[1].px, 4, 3, 1'b0);
        idle();
        chk("hold_sready0", a_s_ready, 0);
        chk_img("hold_keep", 0);
        idle();
        chk_img("hold_stable", 0);
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        chk_img("hold_img2", 1);
        chk("hold_sready_back", a_s_ready, 1);
        @(negedge clk);
        chk("hold_drain", a_m_valid, 0);

        // Final pixel arrives in the same cycle the old image is taken.
        send(tbl[2].px, 4, 3, 1'b0);
        idle();
        chk_img("simul_old", 2);
        send(tbl[4].px, 3, -1, 1'b0);
        push(tbl[4].px[31:24], 1'b1, 1'b1);
        idle();
        chk_img("simul_new", 4);
        chk("simul_sready", a_s_ready, 1);
        idle();
        chk("simul_drain", a_m_valid, 0);

        // Reset while an image is held.
        send(tbl[0].px, 4, 3, 1'b0);
        send(tbl[1].px, 4, 3, 1'b0);
        idle();
        chk("rsthold_in_hold", a_s_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rsthold_mvalid", a_m_valid, 0);
        chk("rsthold_a_data", a_data, 0);
        chk("rsthold_b_data", b_data, 0);
        chk("rsthold_sready", a_s_ready, 0);
        rst = 1'b0;
        send(tbl[3].px, 4, 3, 1'b1);
        idle();
        chk_img("rsthold_next", 3);

        // Random backpressure over 50 full-size images.
        got = 0; cyc = 0; tmo = 1'b0;
        fork
            begin : producer
                for (int img = 0; img < 50 && !tmo; img++) begin
                    logic [NC*BC-1:0] exp_img;
                    logic [7:0]       px;
                    int               k;
                    exp_img = '0;
                    k = 0;
                    px = 8'($urandom_range(0, 255));
                    while (k < NC && !tmo) begin
                        @(negedge clk);
                        c_s_valid = ($urandom_range(0, 9) < 9);
                        c_s_pixel = c_s_valid ? px : 8'($urandom);
                        c_s_last  = c_s_valid ? (k == NC - 1) : 1'($urandom);
                        if (c_s_valid && c_s_ready) begin
                            exp_img[k*BC +: BC] = BC'(px / 32);
                            k++;
                            px = 8'($urandom_range(0, 255));
                        end
                    end
                    exp_q.push_back(exp_img);
                end
                @(negedge clk);
                c_s_valid = 1'b0;
                c_s_last  = 1'b0;
            end
            begin : consumer
                while (got < 50 && !tmo) begin
                    @(negedge clk);
                    cyc++;
                    if (cyc > 90000) tmo = 1'b1;
                    c_m_ready = ($urandom_range(0, 3) != 0);
                    chk("rand_err", c_err, 0);
                    if (c_m_valid) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rand_dup actual=extra_image required=none");
                        end else begin
                            logic [NC*BC-1:0] e;
                            e = exp_q[0];
                            checks++;
                            if (c_data !== e) begin
                                errors++;
                                for (int i = 0; i < NC; i++) begin
                                    if (c_data[i*BC +: BC] !== e[i*BC +: BC]) begin
                                        $display("FAIL rand_data img=%0d pix=%0d actual=%0d required=%0d",
                                                 got, i, c_data[i*BC +: BC], e[i*BC +: BC]);
                                        break;
                                    end
                                end
                            end
                            if (c_m_ready) begin
                                void'(exp_q.pop_front());
                                got++;
                            end
                        end
                    end
                end
                @(negedge clk);
                c_m_ready = 1'b0;
            end
        join
        chk("rand_count", got, 50);
        chk("rand_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
